// File: rtl/attack_matrix_scan_pkg.sv
// Shared geometry, coordinate-code constants and scan state encoding for the
// attack-round LED matrix display.
package attack_matrix_scan_pkg;

  localparam int unsigned DATA_WIDTH    = 35;
  localparam int unsigned COLUNE_SIZE   = 7;
  localparam int unsigned TOTAL_COLUNES = 5;
  localparam int unsigned CODE_W        = 3;
  localparam int unsigned COL_W         = 3;

  // Coordinate codes are 1-based; code 0 means "no cursor".
  localparam logic [CODE_W-1:0] COL_CODE_NONE = 3'd0;
  localparam logic [CODE_W-1:0] CODE_OFFSET   = 3'd1;
  localparam logic [CODE_W-1:0] X_CODE_MAX    = CODE_W'(TOTAL_COLUNES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/attack_matrix_scan_if.sv
// Map/cursor inputs and LED matrix drive outputs of the attack matrix scanner.
interface attack_matrix_scan_if;
  import attack_matrix_scan_pkg::*;

  logic                      enable;
  logic [DATA_WIDTH-1:0]     matriz_data;
  logic [CODE_W-1:0]         x_coord_code;
  logic [CODE_W-1:0]         y_coord_code;
  logic [TOTAL_COLUNES-1:0]  col_sel;
  logic [COLUNE_SIZE-1:0]    row_n;
  logic                      frame_done;

  modport master (
    output enable, matriz_data, x_coord_code, y_coord_code,
    input  col_sel, row_n, frame_done
  );

  modport slave (
    input  enable, matriz_data, x_coord_code, y_coord_code,
    output col_sel, row_n, frame_done
  );

endinterface

// File: rtl/scan_col_decode.sv
// Selects the current column of the frozen frame and overlays the blinking
// cursor pixel, producing the active-low row drive for that column.
module scan_col_decode
  import attack_matrix_scan_pkg::*;
(
  input  logic [COL_W-1:0]        col,
  input  logic [DATA_WIDTH-1:0]   frame_buf,
  input  logic [CODE_W-1:0]       x_coord_code,
  input  logic [CODE_W-1:0]       y_coord_code,
  input  logic                    blink_phase,
  output logic [COLUNE_SIZE-1:0]  row_n_next
);

  logic [COLUNE_SIZE-1:0] col_bits;
  logic [COLUNE_SIZE-1:0] cursor_mask;
  logic                   cursor_hit;

  // Column 0 lives in the top bits of the map.
  always_comb begin
    col_bits = '0;
    for (int c = 0; c < TOTAL_COLUNES; c++) begin
      if (col == COL_W'(c)) begin
        col_bits = frame_buf[DATA_WIDTH-(c+1)*COLUNE_SIZE +: COLUNE_SIZE];
      end
    end
  end

  always_comb begin
    cursor_hit  = (x_coord_code != COL_CODE_NONE) &&
                  (x_coord_code <= X_CODE_MAX) &&
                  ((x_coord_code - CODE_OFFSET) == col) &&
                  (y_coord_code != COL_CODE_NONE);
    cursor_mask = '0;
    if (cursor_hit && blink_phase) begin
      cursor_mask = COLUNE_SIZE'(1) << (y_coord_code - CODE_OFFSET);
    end
    row_n_next = ~(col_bits ^ cursor_mask);
  end

endmodule

// File: rtl/attack_matrix_scan.sv
// Column-multiplexed LED matrix scanner: per-frame map snapshot, blanking gap
// before each column, and a blinking cursor overlay.
module attack_matrix_scan
  import attack_matrix_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic               clk,
  input  logic               reset,
  attack_matrix_scan_if.slave bus
);

  localparam int unsigned CNT_MAX  = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX);
  localparam int unsigned FCNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(TOTAL_COLUNES - 1);

  scan_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [COL_W-1:0]       col;
  logic [FCNT_W-1:0]      frame_cnt;
  logic                   blink_phase;
  logic [DATA_WIDTH-1:0]  frame_buf;
  logic [COLUNE_SIZE-1:0] row_n_next;

  scan_col_decode u_col_decode (
    .col          (col),
    .frame_buf    (frame_buf),
    .x_coord_code (bus.x_coord_code),
    .y_coord_code (bus.y_coord_code),
    .blink_phase  (blink_phase),
    .row_n_next   (row_n_next)
  );

  // Outputs reflect the state held during the previous cycle; enable=0 kills them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      col            <= '0;
      frame_cnt      <= '0;
      blink_phase    <= 1'b0;
      frame_buf      <= '0;
      bus.col_sel    <= '0;
      bus.row_n      <= '1;
      bus.frame_done <= 1'b0;
    end else if (!bus.enable) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      frame_cnt      <= '0;
      blink_phase    <= 1'b0;
      bus.col_sel    <= '0;
      bus.row_n      <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.col_sel    <= '0;
      bus.row_n      <= '1;
      bus.frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          frame_buf <= bus.matriz_data;
          col       <= '0;
          cnt       <= '0;
          state     <= ST_BLANK;
        end
        ST_BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_DRIVE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          bus.col_sel <= TOTAL_COLUNES'(1) << col;
          bus.row_n   <= row_n_next;
          if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt   <= '0;
            state <= ST_BLANK;
            if (col == LAST_COL) begin
              col            <= '0;
              frame_buf      <= bus.matriz_data;
              bus.frame_done <= 1'b1;
              if (frame_cnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attack_matrix_scan.sv
// Self-checking bench for attack_matrix_scan with a timeline-based reference model.
module tb_attack_matrix_scan;

  localparam int SD = 4;
  localparam int BL = 1;
  localparam int BF = 2;
  localparam int L  = BL + SD;
  localparam int F  = 5 * L;

  logic clk;
  logic reset;

  attack_matrix_scan_if ifc ();

  attack_matrix_scan #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since the scan left IDLE, and the frame snapshot.
  logic [34:0] snap;
  bit          running;
  int          t;
  logic [4:0]  exp_col;
  logic [6:0]  exp_row;
  logic        exp_fd;
  int          exp_phase;

  function automatic logic [6:0] ref_row(input logic [34:0] m, input int c,
                                         input int x, input int y, input int ph);
    logic [6:0] b;
    b = 7'((m >> (35 - (c + 1) * 7)) & 35'h7F);
    if (ph == 1 && x >= 1 && x <= 5 && x - 1 == c && y >= 1 && y <= 7)
      b[y-1] = ~b[y-1];
    return ~b;
  endfunction

  // Predicts outputs after the coming rising edge, then waits for it and settles.
  task automatic model_edge();
    int p;
    int c;
    exp_col = 5'd0;
    exp_row = 7'h7F;
    exp_fd  = 1'b0;
    if (!reset || !ifc.enable) begin
      running   = 0;
      exp_phase = 0;
    end else if (!running) begin
      running   = 1;
      t         = 0;
      exp_phase = 0;
      snap      = ifc.matriz_data;
    end else begin
      t         = t + 1;
      p         = t - 1;
      c         = (p / L) % 5;
      exp_phase = ((p / F) / BF) % 2;
      exp_fd    = (t % F == 0);
      if (p % L >= BL) begin
        exp_col = 5'(1 << c);
        exp_row = ref_row(snap, c, int'(ifc.x_coord_code), int'(ifc.y_coord_code), exp_phase);
      end
      if (t % F == 0) snap = ifc.matriz_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [34:0] m, input logic [2:0] x, input logic [2:0] y);
    ifc.enable = 1'b0;
    model_edge();
    ifc.matriz_data  = m;
    ifc.x_coord_code = x;
    ifc.y_coord_code = y;
    ifc.enable       = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    first = -1;
    reset = 1'b0;
    ifc.enable = 1'b1;
    ifc.matriz_data = 35'h0;
    ifc.x_coord_code = 3'd0;
    ifc.y_coord_code = 3'd0;
    running = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {5'd0, 7'h7F, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold got col=%b row=%b fd=%b exp col=00000 row=1111111 fd=0",
                 ifc.col_sel, ifc.row_n, ifc.frame_done);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL reset_release k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
      if (ifc.col_sel === 5'b00001 && first < 0) first = k;
    end
    total++;
    if (first !== 2) begin
      bad++;
      $display("FAIL first_col0_latency got=%0d exp=2", first);
    end
  endtask

  task automatic test_single_pixel();
    int fd_at[$];
    restart(35'h400000000, 3'd0, 3'd0);
    for (int k = 0; k < 2 * F + 5; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL single_pixel k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
      if (ifc.col_sel === 5'b00001) begin
        total++;
        if (ifc.row_n !== 7'b0111111) begin
          bad++;
          $display("FAIL single_pixel_col0 got=%b exp=0111111", ifc.row_n);
        end
      end else if (ifc.col_sel !== 5'd0) begin
        total++;
        if (ifc.row_n !== 7'h7F) begin
          bad++;
          $display("FAIL single_pixel_dark_col got=%b exp=1111111", ifc.row_n);
        end
      end
      if (ifc.frame_done === 1'b1) fd_at.push_back(k);
    end
    total++;
    if (fd_at.size() != 2 || fd_at[0] != F || fd_at[1] - fd_at[0] != F) begin
      bad++;
      $display("FAIL frame_done_period got count=%0d exp count=2 spacing=%0d", fd_at.size(), F);
    end
  endtask

  task automatic test_mid_frame_change();
    logic [34:0] a;
    logic [34:0] b;
    logic [6:0]  b_col0;
    bit changed;
    bit seen_fd;
    bit checked;
    a = 35'({$urandom, $urandom});
    b = ~a;
    b_col0 = b[34:28];
    changed = 0;
    seen_fd = 0;
    checked = 0;
    restart(a, 3'd0, 3'd0);
    for (int k = 0; k < 2 * F; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL mid_frame k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
      if (ifc.frame_done === 1'b1) seen_fd = 1;
      if (seen_fd && !checked && ifc.col_sel === 5'b00001) begin
        checked = 1;
        total++;
        if (ifc.row_n !== ~b_col0) begin
          bad++;
          $display("FAIL new_data_col0 got=%b exp=%b", ifc.row_n, ~b_col0);
        end
      end
      if (!changed && ifc.col_sel === 5'b00100) begin
        changed = 1;
        ifc.matriz_data = b;
      end
    end
    total++;
    if (!checked) begin
      bad++;
      $display("FAIL new_data_col0 got=not_seen exp=seen");
    end
  endtask

  task automatic test_cursor_blink();
    int lit;
    lit = 0;
    restart(35'h0, 3'd3, 3'd2);
    for (int k = 0; k < 5 * F; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL cursor k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
      if (ifc.col_sel === 5'b00100) begin
        total++;
        if (ifc.row_n !== (exp_phase == 1 ? 7'b1111101 : 7'h7F)) begin
          bad++;
          $display("FAIL cursor_col2 phase=%0d got=%b", exp_phase, ifc.row_n);
        end
        if (ifc.row_n === 7'b1111101) lit++;
      end
    end
    total++;
    if (lit != 2 * SD) begin
      bad++;
      $display("FAIL cursor_lit_cycles got=%0d exp=%0d", lit, 2 * SD);
    end
  endtask

  task automatic test_enable_drop();
    bit dropped;
    dropped = 0;
    restart(35'({$urandom, $urandom}), 3'd4, 3'd5);
    for (int k = 0; k < 2 * F; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL enable_drop k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
      if (!dropped && ifc.col_sel === 5'b01000) begin
        dropped = 1;
        ifc.enable = 1'b0;
        model_edge();
        total++;
        if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {5'd0, 7'h7F, 1'b0}) begin
          bad++;
          $display("FAIL enable_drop_off got %b/%b/%b exp 00000/1111111/0",
                   ifc.col_sel, ifc.row_n, ifc.frame_done);
        end
        ifc.enable = 1'b1;
      end
    end
  endtask

  task automatic test_cursor_edge_cases();
    logic [2:0] xs [4];
    logic [2:0] ys [4];
    logic [34:0] ms [4];
    xs = '{3'd6, 3'd3, 3'd7, 3'd1};
    ys = '{3'd3, 3'd0, 3'd1, 3'd1};
    ms = '{35'h0, 35'h0, 35'h7FFFFFFFF, 35'h7FFFFFFFF};
    for (int s = 0; s < 4; s++) begin
      restart(ms[s], xs[s], ys[s]);
      for (int k = 0; k < 4 * F; k++) begin
        model_edge();
        total++;
        if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
          bad++;
          $display("FAIL cursor_edge s=%0d k=%0d got %b/%b/%b exp %b/%b/%b", s, k,
                   ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
        end
        if (s == 3 && ifc.col_sel === 5'b00001) begin
          total++;
          if (ifc.row_n !== (exp_phase == 1 ? 7'b0000001 : 7'b0000000)) begin
            bad++;
            $display("FAIL cursor_on_lit phase=%0d got=%b", exp_phase, ifc.row_n);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    restart(35'({$urandom, $urandom}), 3'($urandom), 3'($urandom));
    for (int k = 0; k < 1500; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL random k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
      if ($urandom_range(0, 9) == 0) ifc.matriz_data = 35'({$urandom, $urandom});
      if ($urandom_range(0, 19) == 0) begin
        ifc.x_coord_code = 3'($urandom);
        ifc.y_coord_code = 3'($urandom);
      end
      if (!ifc.enable) ifc.enable = 1'b1;
      else if ($urandom_range(0, 199) == 0) ifc.enable = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    restart(35'h123456789, 3'd2, 3'd4);
    for (int k = 0; k < F + 7; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL pre_reset k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {5'd0, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got %b/%b/%b exp 00000/1111111/0",
               ifc.col_sel, ifc.row_n, ifc.frame_done);
    end
    running = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < F + 3; k++) begin
      model_edge();
      total++;
      if ({ifc.col_sel, ifc.row_n, ifc.frame_done} !== {exp_col, exp_row, exp_fd}) begin
        bad++;
        $display("FAIL post_reset k=%0d got %b/%b/%b exp %b/%b/%b", k,
                 ifc.col_sel, ifc.row_n, ifc.frame_done, exp_col, exp_row, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_mid_frame_change();
    test_cursor_blink();
    test_enable_drop();
    test_cursor_edge_cases();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
